// File: rtl/gf180mcu_ws_io_pwr_pkg.sv
// ---------------------------------------------------------------------------
// gf180mcu_ws_io_pwr_pkg
// Shared types and defaults for the pad-ring I/O supply sequencer.
//   pwr_state_e : sequencer states (OFF, UP_WAIT, ON, DN_WAIT, FAULT)
//   *_DEF       : default parameter values for gf180mcu_ws_io_pwr_seq
//   IDX_W_DEF   : segment index width for the default segment count
// ---------------------------------------------------------------------------
package gf180mcu_ws_io_pwr_pkg;

  typedef enum logic [2:0] {
    OFF     = 3'd0,
    UP_WAIT = 3'd1,
    ON      = 3'd2,
    DN_WAIT = 3'd3,
    FAULT   = 3'd4
  } pwr_state_e;

  localparam int unsigned N_SEG_DEF       = 4;
  localparam int unsigned SETTLE_CYC_DEF  = 16;
  localparam int unsigned TIMEOUT_CYC_DEF = 255;
  localparam int unsigned CNT_W_DEF       = 8;

  localparam int unsigned IDX_W_DEF = $clog2(N_SEG_DEF);

endpackage

// File: rtl/gf180mcu_ws_io_pg_sync.sv
// ---------------------------------------------------------------------------
// gf180mcu_ws_io_pg_sync
// Two-flop synchroniser for the asynchronous segment power-good inputs.
// Both stages reset to 0 so a freshly reset sequencer never sees stale
// power-good.
//   clk : sampling clock
//   rst : synchronous active-high reset
//   d   : asynchronous input bus (WIDTH bits)
//   q   : synchronised output bus (WIDTH bits, 2 cycles of latency)
// ---------------------------------------------------------------------------
module gf180mcu_ws_io_pg_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/gf180mcu_ws_io_pwr_seq.sv
// ---------------------------------------------------------------------------
// gf180mcu_ws_io_pwr_seq
// Pad-ring I/O supply sequencer: enables N_SEG DVDD/DVSS segments in
// ascending order and disables them in descending order, waiting for each
// segment's power-good to be stable for SETTLE_CYC cycles. A step that takes
// TIMEOUT_CYC cycles, or a lost supply while ON, latches a sticky fault.
//
// Build option: define GF180MCU_WS_IO_PWR_SEQ_PG_SYNC_EN to pass seg_pg
// through a 2-flop synchroniser (adds 2 cycles per step). Without it seg_pg
// must already be synchronous to clk.
//
// Ports:
//   clk       : clock
//   rst       : synchronous active-high reset
//   pwr_req   : 1 = ring powered, 0 = ring off (level)
//   pwr_ack   : 1 only in ON
//   busy      : 1 while sequencing up or down
//   seg_en    : per-segment supply-switch enables
//   seg_pg    : per-segment power-good
//   fault     : sticky fault flag
//   fault_seg : segment index that faulted
//   fault_clr : clears fault, accepted only while pwr_req = 0
// ---------------------------------------------------------------------------
module gf180mcu_ws_io_pwr_seq
  import gf180mcu_ws_io_pwr_pkg::*;
#(
  parameter int unsigned N_SEG       = N_SEG_DEF,
  parameter int unsigned SETTLE_CYC  = SETTLE_CYC_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pwr_req,
  output logic                     pwr_ack,
  output logic                     busy,
  output logic [N_SEG-1:0]         seg_en,
  input  logic [N_SEG-1:0]         seg_pg,
  output logic                     fault,
  output logic [$clog2(N_SEG)-1:0] fault_seg,
  input  logic                     fault_clr
);

  localparam int unsigned IDX_W = $clog2(N_SEG);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_SEG - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  // Fault fires on the edge where the step count would reach TIMEOUT_CYC.
  localparam logic [CNT_W-1:0] STEP_LAST   = CNT_W'(TIMEOUT_CYC - 1);

  pwr_state_e       state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] settle_cnt;
  logic [CNT_W-1:0] step_cnt;
  logic [N_SEG-1:0] pg_s;
  logic [IDX_W-1:0] low_fail;

`ifdef GF180MCU_WS_IO_PWR_SEQ_PG_SYNC_EN
  gf180mcu_ws_io_pg_sync #(
    .WIDTH (N_SEG)
  ) u_pg_sync (
    .clk (clk),
    .rst (rst),
    .d   (seg_pg),
    .q   (pg_s)
  );
`else
  assign pg_s = seg_pg;
`endif

  // Lowest-numbered segment whose power-good is missing.
  always_comb begin
    low_fail = '0;
    for (int i = N_SEG - 1; i >= 0; i--) begin
      if (!pg_s[i]) low_fail = IDX_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= OFF;
      idx        <= '0;
      settle_cnt <= '0;
      step_cnt   <= '0;
      seg_en     <= '0;
      pwr_ack    <= 1'b0;
      busy       <= 1'b0;
      fault      <= 1'b0;
      fault_seg  <= '0;
    end else begin
      case (state)
        OFF: begin
          if (pwr_req) begin
            state      <= UP_WAIT;
            seg_en     <= '0;
            seg_en[0]  <= 1'b1;
            idx        <= '0;
            settle_cnt <= '0;
            step_cnt   <= '0;
            busy       <= 1'b1;
          end
        end

        UP_WAIT: begin
          if (!pwr_req) begin
            state       <= DN_WAIT;
            seg_en[idx] <= 1'b0;
            settle_cnt  <= '0;
            step_cnt    <= '0;
          end else if (pg_s[idx] && settle_cnt == SETTLE_LAST) begin
            // Completion is checked before timeout so it wins a tie.
            settle_cnt <= '0;
            step_cnt   <= '0;
            if (idx != LAST_IDX) begin
              seg_en[idx + 1'b1] <= 1'b1;
              idx                <= idx + 1'b1;
            end else begin
              state   <= ON;
              pwr_ack <= 1'b1;
              busy    <= 1'b0;
            end
          end else if (step_cnt == STEP_LAST) begin
            state      <= FAULT;
            seg_en     <= '0;
            busy       <= 1'b0;
            fault      <= 1'b1;
            fault_seg  <= idx;
            settle_cnt <= '0;
            step_cnt   <= '0;
          end else begin
            settle_cnt <= pg_s[idx] ? settle_cnt + 1'b1 : '0;
            step_cnt   <= step_cnt + 1'b1;
          end
        end

        ON: begin
          if (!pwr_req) begin
            state             <= DN_WAIT;
            idx               <= LAST_IDX;
            seg_en[N_SEG - 1] <= 1'b0;
            pwr_ack           <= 1'b0;
            busy              <= 1'b1;
            settle_cnt        <= '0;
            step_cnt          <= '0;
          end else if (!(&pg_s)) begin
            state     <= FAULT;
            seg_en    <= '0;
            pwr_ack   <= 1'b0;
            fault     <= 1'b1;
            fault_seg <= low_fail;
          end
        end

        DN_WAIT: begin
          // pwr_req is deliberately ignored so power-down always completes.
          if (!pg_s[idx] && settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            step_cnt   <= '0;
            if (idx != '0) begin
              seg_en[idx - 1'b1] <= 1'b0;
              idx                <= idx - 1'b1;
            end else begin
              state <= OFF;
              busy  <= 1'b0;
            end
          end else if (step_cnt == STEP_LAST) begin
            state      <= FAULT;
            seg_en     <= '0;
            busy       <= 1'b0;
            fault      <= 1'b1;
            fault_seg  <= idx;
            settle_cnt <= '0;
            step_cnt   <= '0;
          end else begin
            settle_cnt <= !pg_s[idx] ? settle_cnt + 1'b1 : '0;
            step_cnt   <= step_cnt + 1'b1;
          end
        end

        FAULT: begin
          if (fault_clr && !pwr_req) begin
            state <= OFF;
            fault <= 1'b0;
          end
        end

        default: begin
          state  <= OFF;
          seg_en <= '0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/gf180mcu_ws_io_pwr_seq.md
# gf180mcu_ws_io_pwr_seq

Digital sequencer for the pad-ring I/O supply segments: it switches N DVDD/DVSS pad-ring segments on in ascending order and off in descending order. Each step waits for that segment's power-good to settle. It watches for timeouts and lost supplies, and gives the core a single request/acknowledge handshake. It sits in the always-on padframe control logic, between the SoC power manager and the segment power-switch enables.

## Interface
- `N_SEG`, 4: number of pad-ring supply segments (2..8).
- `SETTLE_CYC`, 16: consecutive cycles `seg_pg` must be stable before a step is accepted (≥1).
- `TIMEOUT_CYC`, 255: maximum cycles allowed per step, counted from the enable change. Must exceed `SETTLE_CYC`+3.
- `CNT_W`, 8: counter width; must hold `TIMEOUT_CYC`.
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `pwr_req`  in  1  level: 1 = ring powered, 0 = ring off.
- `pwr_ack`  out  1  1 only in ON (all segments enabled and settled).
- `busy`  out  1  1 while sequencing up or down.
- `seg_en`  out  N_SEG  per-segment supply-switch enable.
- `seg_pg`  in  N_SEG  per-segment power-good; asynchronous to `clk`.
- `fault`  out  1  sticky fault flag.
- `fault_seg`  out  $clog2(N_SEG)  index of the segment that faulted.
- `fault_clr`  in  1  clears the fault; accepted only while `pwr_req`=0.

## Operation
- States: OFF, UP_WAIT, ON, DN_WAIT, FAULT. Index register `idx` holds the current segment.
- Reset: state OFF, `idx`=0, counters 0, all outputs 0.
- **OFF to UP_WAIT**
  - Transition occurs on the edge where `pwr_req`=1.
  - On that edge `seg_en[0]` is set, `idx`=0, and both counters are cleared.
- **UP_WAIT**
  - The settle counter increments each cycle the synchronised `pg[idx]`=1 and clears to 0 on any cycle it is 0.
  - Step complete: when the settle counter is at `SETTLE_CYC`-1 and `pg[idx]`=1, the step completes on that edge.
  - If `idx`<N_SEG-1, the step sets `seg_en[idx+1]`, increments `idx`, and clears both counters.
  - Otherwise it goes to ON.
  - Timeout: the step counter increments every cycle. At `TIMEOUT_CYC` go to FAULT.
  - Abort: `pwr_req`=0 in UP_WAIT goes to DN_WAIT on the same edge. It clears `seg_en[idx]`, keeps `idx`, and clears the counters.
- **ON**
  - Entering ON sets `pwr_ack`=1 on that edge.
  - `pwr_req`=0 goes to DN_WAIT with `idx`=N_SEG-1. It clears `seg_en[N_SEG-1]` and `pwr_ack`.
  - Any synchronised `pg` bit equal to 0 goes to FAULT. `fault_seg` is the lowest failing index.
- **DN_WAIT** mirrors UP_WAIT, with these differences:
  - It waits for `pg[idx]`=0 to be stable.
  - On completion it clears `seg_en[idx-1]` and decrements `idx`. At `idx`=0 it goes to OFF.
  - It has the same timeout behaviour.
  - `pwr_req` returning to 1 is ignored until OFF is reached, so power-down always completes.
- **FAULT**
  - All `seg_en` are cleared on the entry edge. `fault`=1, `fault_seg`=`idx`, `busy`=0.
  - The state is held until `fault_clr`=1 and `pwr_req`=0, then it goes to OFF and `fault` clears.
  - `fault_clr` with `pwr_req`=1 is ignored.
- `busy`=1 exactly in UP_WAIT and DN_WAIT.
- Simultaneous step completion and timeout on the same edge: completion wins.

## Timing
- All outputs are registered; no combinational input-to-output path.
- With `PG_SYNC` off and `pg` already valid:
  - `seg_en[0]` rises 1 cycle after `pwr_req` is sampled.
  - `seg_en[i]` rises at cycle 1+i·SETTLE_CYC.
  - `pwr_ack` rises at cycle 1+N_SEG·SETTLE_CYC.
- With `PG_SYNC`, add 2 cycles per step.
- Power-down is symmetric: `pwr_ack` falls 1 cycle after `pwr_req` falls, and `busy` falls at cycle 1+N_SEG·SETTLE_CYC(+2 per step).
- Reset mid-sequence: all `seg_en` read 0 in the cycle after the reset edge, and no power-down ordering is applied.

## Configuration
- Macro: `GF180MCU_WS_IO_PWR_SEQ_PG_SYNC_EN`.
- Defined: each `seg_pg` bit passes through a 2-flop synchroniser (reset to 0) before use.
- Undefined: `seg_pg` is used directly and must already be synchronous to `clk`; this removes 2 cycles of latency per step.

## Structure
- Package `gf180mcu_ws_io_pwr_pkg` holds:
  - the state enum `pwr_state_e` (OFF, UP_WAIT, ON, DN_WAIT, FAULT);
  - the default parameter constants;
  - the localparam for the index width.
- Sub-module `gf180mcu_ws_io_pg_sync`: a parameterised-width 2-flop synchroniser, instantiated only under the macro.
- The FSM and counters live in the top module.

## Test plan
All scenarios use N_SEG=4, SETTLE_CYC=4, TIMEOUT_CYC=20, with the macro undefined unless stated.
- **Normal power-up.** Drive `pwr_req`=1 with `pg` following `en` 1 cycle later.
  - `seg_en` goes 0001, 0011, 0111, 1111 at cycles 1, 6, 11, 16.
  - `pwr_ack`=1 at cycle 21.
  - `busy` is high for cycles 1–20.
- **Normal power-down.** Drive `pwr_req`=0 from ON.
  - `seg_en` is cleared in order 1111, 0111, 0011, 0001, 0000 (descending).
  - `pwr_ack` drops after 1 cycle; the sequence ends in OFF with `busy`=0.
- **Up-step timeout.** Hold `seg_pg[2]` at 0.
  - FAULT is entered 20 cycles after `seg_en[2]` rises.
  - `seg_en`=0000, `fault`=1, `fault_seg`=2.
  - `fault_clr` with `pwr_req`=1 is ignored; with `pwr_req`=0 it returns to OFF.
- **Glitch during settle.** `seg_pg[1]` drops for 1 cycle at settle count 2.
  - The settle counter restarts and `seg_en[2]` rises 3 cycles later than nominal.
- **Abort and supply loss.**
  - `pwr_req`=0 while in UP_WAIT at `idx`=1: immediate descending power-down from segment 1.
  - In ON, `seg_pg[3]` goes to 0: FAULT with `fault_seg`=3.
- **Synchroniser and reset, with the macro defined.**
  - The full power-up takes 29 cycles.
  - Asserting `rst` mid-sequence gives all outputs 0 on the next cycle.
